iter_divider: RTL and testbench



---
 rtl/iter_divider.sv | 187 ++++++++++++++++++
 tb/tb_iter_divider.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// iter_divider: multi-cycle radix-2 restoring divider serving DIV/DIVU/REM/REMU
// and their 32-bit W forms. One quotient bit is produced per CALC cycle. The
// operands are reduced to magnitudes at accept, and the signs are re-applied on
// the final CALC edge.
//
// Optional build macro DIV_EARLY_FINISH_EN: when this macro is defined, an accepted
// request with |dividend| < |divisor| (non-zero divisor) finishes at once with
// quotient 0. The results are the same in both builds. Only the latency differs.

module iter_divider #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_valid,
  input  logic             flush,
  input  logic             divw,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             div_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  // W-form operations work on the low half of a 64-bit datapath
  localparam int HALF = 32;
  // Counter must reach WIDTH itself, because that value marks the fixup edge
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem_acc;
  logic [WIDTH-1:0] q_acc;
  logic [WIDTH-1:0] dvs_mag_r;
  logic             q_neg;
  logic             r_neg;
  logic             is_w;

  // Accept-time operand preparation
  logic [WIDTH-1:0] eff_dvd;
  logic [WIDTH-1:0] eff_dvs;
  logic [WIDTH-1:0] dvd_ext;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] iter_load;
  logic             div_zero;

  // Iteration datapath
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             fits;
  logic [WIDTH-1:0] next_rem;
  logic [WIDTH-1:0] next_q;
  logic [CW-1:0]    last_count;

  // Final sign fixup datapath
  logic [WIDTH-1:0] q_raw;
  logic [WIDTH-1:0] q_signed;
  logic [WIDTH-1:0] r_signed;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;

  // Sign-extend a 32-bit value to the full datapath width
  function automatic logic [WIDTH-1:0] sext32(input logic [HALF-1:0] v);
    return {{(WIDTH-HALF){v[HALF-1]}}, v};
  endfunction

  // Zero-extend a 32-bit value to the full datapath width
  function automatic logic [WIDTH-1:0] zext32(input logic [HALF-1:0] v);
    return {{(WIDTH-HALF){1'b0}}, v};
  endfunction

  assign div_ready = (state == IDLE);
  assign out_valid = (state == DONE);

  // Reduce the raw operands to effective values, signs and magnitudes for an accept this cycle
  always_comb begin
    eff_dvd = dividend;
    eff_dvs = divisor;
    if (divw) begin
      eff_dvd = div_signed ? sext32(dividend[HALF-1:0]) : zext32(dividend[HALF-1:0]);
      eff_dvs = div_signed ? sext32(divisor[HALF-1:0])  : zext32(divisor[HALF-1:0]);
    end
    dvd_ext   = divw ? sext32(dividend[HALF-1:0]) : dividend;
    dvd_neg   = div_signed & eff_dvd[WIDTH-1];
    dvs_neg   = div_signed & eff_dvs[WIDTH-1];
    dvd_mag   = dvd_neg ? -eff_dvd : eff_dvd;
    dvs_mag   = dvs_neg ? -eff_dvs : eff_dvs;
    div_zero  = (eff_dvs == '0);
    // W magnitudes go into the top half so that the first shifts bring in real dividend bits
    iter_load = divw ? {dvd_mag[HALF-1:0], {(WIDTH-HALF){1'b0}}} : dvd_mag;
  end

  // One restoring step: shift in the next dividend bit and trial-subtract the divisor
  always_comb begin
    shifted    = {rem_acc, q_acc[WIDTH-1]};
    trial      = shifted[WIDTH-1:0] - dvs_mag_r;
    fits       = (shifted >= {1'b0, dvs_mag_r});
    next_rem   = fits ? trial : shifted[WIDTH-1:0];
    next_q     = {q_acc[WIDTH-2:0], fits};
    last_count = is_w ? CW'(HALF) : CW'(WIDTH);
  end

  // Re-apply the signs and, for W forms, sign-extend bit 31 of both results
  always_comb begin
    q_raw    = is_w ? zext32(q_acc[HALF-1:0]) : q_acc;
    q_signed = q_neg ? -q_raw : q_raw;
    r_signed = r_neg ? -rem_acc : rem_acc;
    q_final  = is_w ? sext32(q_signed[HALF-1:0]) : q_signed;
    r_final  = is_w ? sext32(r_signed[HALF-1:0]) : r_signed;
  end

  // Control FSM and datapath registers. Flush wins over accept. Results are written only on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      rem_acc   <= '0;
      q_acc     <= '0;
      dvs_mag_r <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      is_w      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (div_valid) begin
            is_w      <= divw;
            q_neg     <= dvd_neg ^ dvs_neg;
            r_neg     <= dvd_neg;
            dvs_mag_r <= dvs_mag;
            count     <= '0;
            rem_acc   <= '0;
            q_acc     <= iter_load;
            if (div_zero) begin
              quotient  <= '1;
              remainder <= dvd_ext;
              state     <= DONE;
            end
`ifdef DIV_EARLY_FINISH_EN
            else if (dvd_mag < dvs_mag) begin
              quotient  <= '0;
              remainder <= dvd_ext;
              state     <= DONE;
            end
`endif
            else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (count == last_count) begin
            quotient  <= q_final;
            remainder <= r_final;
            state     <= DONE;
          end else begin
            rem_acc <= next_rem;
            q_acc   <= next_q;
            count   <= count + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: directed self-checking bench for iter_divider.
// Latency is counted as the number of clock edges after the accept edge that
// occur before out_valid is seen high. A full 64-bit op takes 65 edges, a W op
// takes 33 edges, and an immediate finish takes 0 edges (out_valid in the cycle
// right after accept).

module tb_iter_divider;

  logic        clk;
  logic        rst;
  logic        div_valid;
  logic        flush;
  logic        divw;
  logic        div_signed;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        div_ready;
  logic        out_valid;
  logic [63:0] quotient;
  logic [63:0] remainder;

  int passed;
  int total;
  logic [63:0] last_q;
  logic [63:0] last_r;

  typedef struct {
    logic        w;
    logic        s;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] q;
    logic [63:0] r;
    int          edges;
    string       name;
  } vec_t;

  iter_divider #(.WIDTH(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_valid  (div_valid),
    .flush      (flush),
    .divw       (divw),
    .div_signed (div_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .div_ready  (div_ready),
    .out_valid  (out_valid),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  // Free-running clock with a 10-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issue one request, scramble the operands after accept, and wait (bounded) for out_valid
  task automatic run_op(input logic w, input logic s, input logic [63:0] a, input logic [63:0] b,
                        output logic got, output int edges, output logic [63:0] q,
                        output logic [63:0] r, output logic busy_ok, output logic pulse_ok);
    got = 1'b0; edges = 0; q = '0; r = '0; busy_ok = 1'b1; pulse_ok = 1'b0;
    @(negedge clk);
    divw = w; div_signed = s; dividend = a; divisor = b; div_valid = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0; dividend = 64'hDEAD_BEEF_0BAD_F00D; divisor = 64'h3;
    divw = ~w; div_signed = ~s;
    while (!got && edges < 200) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1; q = quotient; r = remainder;
      end else begin
        if (div_ready) busy_ok = 1'b0;
        @(posedge clk);
        edges++;
      end
    end
    if (got) begin
      @(negedge clk);
      pulse_ok = !out_valid && div_ready;
    end
  endtask

  // Reset values while rst is held
  task automatic test_reset();
    rst = 1'b1; div_valid = 1'b0; flush = 1'b0; divw = 1'b0; div_signed = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (div_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", div_ready);
    else passed++;
    total++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", out_valid);
    else passed++;
    total++;
    if (quotient !== 64'h0 || remainder !== 64'h0)
      $display("[TB] FAIL reset_results: got q=%h r=%h expected 0/0", quotient, remainder);
    else passed++;
    rst = 1'b0;
    last_q = '0; last_r = '0;
  endtask

  // Main arithmetic: unsigned, signed, overflow and W forms, with latency and handshake checks
  task automatic test_basic_ops();
    vec_t tbl[8];
    logic got, busy_ok, pulse_ok;
    int edges;
    logic [63:0] q, r;
    tbl[0] = '{1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65, "u64_100_7"};
    tbl[1] = '{1'b0, 1'b1, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFFF, 65, "s64_m7_2"};
    tbl[2] = '{1'b0, 1'b1, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 64'h0, 65, "s64_min_m1"};
    tbl[3] = '{1'b0, 1'b1, 64'd7, 64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFFFD, 64'd1, 65, "s64_7_m2"};
    tbl[4] = '{1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h10, 64'h0FFFFFFFFFFFFFFF, 64'hF, 65, "u64_max_16"};
    tbl[5] = '{1'b1, 1'b1, 64'h0000000080000000, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000, 64'h0, 33, "w_s_min_m1"};
    tbl[6] = '{1'b1, 1'b0, 64'hABCD0000FFFFFFFF, 64'd1, 64'hFFFFFFFFFFFFFFFF, 64'h0, 33, "w_u_ffff_1"};
    tbl[7] = '{1'b1, 1'b1, 64'h00000000FFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFFF, 33, "w_s_m7_2"};
    foreach (tbl[i]) begin
      run_op(tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].b, got, edges, q, r, busy_ok, pulse_ok);
      total++;
      if (!got) $display("[TB] FAIL %s_timeout: got no out_valid expected out_valid", tbl[i].name);
      else passed++;
      total++;
      if (q !== tbl[i].q) $display("[TB] FAIL %s_quotient: got %h expected %h", tbl[i].name, q, tbl[i].q);
      else passed++;
      total++;
      if (r !== tbl[i].r) $display("[TB] FAIL %s_remainder: got %h expected %h", tbl[i].name, r, tbl[i].r);
      else passed++;
      total++;
      if (edges !== tbl[i].edges) $display("[TB] FAIL %s_latency: got %0d expected %0d", tbl[i].name, edges, tbl[i].edges);
      else passed++;
      total++;
      if (!busy_ok) $display("[TB] FAIL %s_busy: got div_ready=1 while busy expected 0", tbl[i].name);
      else passed++;
      total++;
      if (!pulse_ok) $display("[TB] FAIL %s_pulse: got out_valid not single-cycle expected one-cycle pulse", tbl[i].name);
      else passed++;
      last_q = tbl[i].q; last_r = tbl[i].r;
    end
  endtask

  // Divide by zero finishes in the cycle after accept
  task automatic test_div_zero();
    vec_t tbl[3];
    logic got, busy_ok, pulse_ok;
    int edges;
    logic [63:0] q, r;
    tbl[0] = '{1'b0, 1'b0, 64'h1234, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h1234, 0, "dz_u64"};
    tbl[1] = '{1'b1, 1'b0, 64'h12345678_80000001, 64'hFFFFFFFF_00000000, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000001, 0, "dz_w_u"};
    tbl[2] = '{1'b1, 1'b1, 64'h00000000FFFFFFFF, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 0, "dz_w_s"};
    foreach (tbl[i]) begin
      run_op(tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].b, got, edges, q, r, busy_ok, pulse_ok);
      total++;
      if (!got) $display("[TB] FAIL %s_timeout: got no out_valid expected out_valid", tbl[i].name);
      else passed++;
      total++;
      if (q !== tbl[i].q) $display("[TB] FAIL %s_quotient: got %h expected %h", tbl[i].name, q, tbl[i].q);
      else passed++;
      total++;
      if (r !== tbl[i].r) $display("[TB] FAIL %s_remainder: got %h expected %h", tbl[i].name, r, tbl[i].r);
      else passed++;
      total++;
      if (edges !== tbl[i].edges) $display("[TB] FAIL %s_latency: got %0d expected %0d", tbl[i].name, edges, tbl[i].edges);
      else passed++;
      total++;
      if (!pulse_ok) $display("[TB] FAIL %s_pulse: got out_valid not single-cycle expected one-cycle pulse", tbl[i].name);
      else passed++;
      last_q = tbl[i].q; last_r = tbl[i].r;
    end
  endtask

  // Flush on the 10th CALC cycle of 1000/3 discards the result, and then 9/3 runs normally
  task automatic test_flush();
    logic got, busy_ok, pulse_ok;
    int edges, seen;
    logic [63:0] q, r;
    @(negedge clk);
    divw = 1'b0; div_signed = 1'b0; dividend = 64'd1000; divisor = 64'd3; div_valid = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    total++;
    if (div_ready !== 1'b1) $display("[TB] FAIL flush_ready: got %b expected 1", div_ready);
    else passed++;
    total++;
    if (quotient !== last_q || remainder !== last_r)
      $display("[TB] FAIL flush_hold: got q=%h r=%h expected q=%h r=%h", quotient, remainder, last_q, last_r);
    else passed++;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) $display("[TB] FAIL flush_no_valid: got %0d pulses expected 0", seen);
    else passed++;
    run_op(1'b0, 1'b0, 64'd9, 64'd3, got, edges, q, r, busy_ok, pulse_ok);
    total++;
    if (!got || q !== 64'd3 || r !== 64'd0)
      $display("[TB] FAIL after_flush_9_3: got valid=%b q=%h r=%h expected valid=1 q=3 r=0", got, q, r);
    else passed++;
    total++;
    if (edges !== 65) $display("[TB] FAIL after_flush_latency: got %0d expected 65", edges);
    else passed++;
    last_q = 64'd3; last_r = 64'd0;
  endtask

  // Flush in IDLE blocks a simultaneous request (a divide-by-zero that would otherwise finish at once)
  task automatic test_flush_accept();
    @(negedge clk);
    divw = 1'b0; div_signed = 1'b0; dividend = 64'h77; divisor = 64'h0;
    div_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || div_ready !== 1'b1)
      $display("[TB] FAIL flush_accept: got valid=%b ready=%b expected valid=0 ready=1", out_valid, div_ready);
    else passed++;
    total++;
    if (quotient !== last_q || remainder !== last_r)
      $display("[TB] FAIL flush_accept_hold: got q=%h r=%h expected q=%h r=%h", quotient, remainder, last_q, last_r);
    else passed++;
  endtask

  // rst mid-CALC restores the reset values and suppresses the pending result
  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    divw = 1'b0; div_signed = 1'b0; dividend = 64'd100; divisor = 64'd7; div_valid = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (div_ready !== 1'b1 || out_valid !== 1'b0)
      $display("[TB] FAIL reset_mid_ctrl: got ready=%b valid=%b expected ready=1 valid=0", div_ready, out_valid);
    else passed++;
    total++;
    if (quotient !== 64'h0 || remainder !== 64'h0)
      $display("[TB] FAIL reset_mid_results: got q=%h r=%h expected 0/0", quotient, remainder);
    else passed++;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) $display("[TB] FAIL reset_mid_no_valid: got %0d pulses expected 0", seen);
    else passed++;
    last_q = '0; last_r = '0;
  endtask

  // Small dividend: same result in both builds, latency depends on the early-finish option
  task automatic test_early_finish();
    logic got, busy_ok, pulse_ok;
    int edges, exp_edges;
    logic [63:0] q, r;
`ifdef DIV_EARLY_FINISH_EN
    exp_edges = 0;
`else
    exp_edges = 65;
`endif
    run_op(1'b0, 1'b0, 64'd5, 64'd9, got, edges, q, r, busy_ok, pulse_ok);
    total++;
    if (!got || q !== 64'd0 || r !== 64'd5)
      $display("[TB] FAIL early_5_9: got valid=%b q=%h r=%h expected valid=1 q=0 r=5", got, q, r);
    else passed++;
    total++;
    if (edges !== exp_edges) $display("[TB] FAIL early_latency: got %0d expected %0d", edges, exp_edges);
    else passed++;
    run_op(1'b1, 1'b1, 64'h00000000FFFFFFFB, 64'd9, got, edges, q, r, busy_ok, pulse_ok);
    total++;
    if (!got || q !== 64'd0 || r !== 64'hFFFFFFFFFFFFFFFB)
      $display("[TB] FAIL early_w_m5_9: got valid=%b q=%h r=%h expected valid=1 q=0 r=fffffffffffffffb", got, q, r);
    else passed++;
  endtask

  // Run every scenario in sequence and then print the summary
  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_basic_ops();
    test_div_zero();
    test_flush();
    test_flush_accept();
    test_reset_mid();
    test_early_finish();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
